// File: rtl/booth_mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM state
// encodings, the Booth digit set and the 3-bit window recoder.
package booth_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

  // Standard radix-4 recoding of {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_e booth_recode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mul_seq_digit_sel.sv
// Combinational Booth multiple selector: turns a 3-bit multiplier window and
// the extended multiplicand into 0, +A, +2A, -A or -2A (WIDTH+3 bits, signed).
module booth_digit_sel
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] multiple
);

  logic [WIDTH+2:0] a1;
  logic [WIDTH+2:0] a2;

  assign a1 = {a_ext[WIDTH+1], a_ext};
  assign a2 = {a_ext, 1'b0};

  // Pick the signed multiple for the recoded digit
  always_comb begin
    multiple = '0;
    case (booth_recode(window))
      POS1:    multiple = a1;
      POS2:    multiple = a2;
      NEG1:    multiple = -a1;
      NEG2:    multiple = -a2;
      default: multiple = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on
// both sides, signed/unsigned per transaction.
// Optional: define BOOTH_MUL_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all equal (remaining digits are all zero).
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = 2*WIDTH + 2;     // accumulator width
  localparam int BW = WIDTH + 3;       // extended multiplier incl. b[-1]
  localparam int IW = $clog2(WIDTH/2 + 2);

  logic [1:0]       state;
  logic [WIDTH+1:0] a_ext;
  logic [BW-1:0]    b_sh;              // multiplier, shifted so window is [2:0]
  logic [AW-1:0]    acc;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last_idx;
  logic [WIDTH+2:0] multiple;
  logic [AW-1:0]    addend;
  logic             skip;
  logic [1:0]       a_top;
  logic [1:0]       b_top;

  booth_digit_sel #(.WIDTH(WIDTH)) u_sel (
    .window   (b_sh[2:0]),
    .a_ext    (a_ext),
    .multiple (multiple)
  );

  assign addend = {{(AW-BW){multiple[WIDTH+2]}}, multiple} << {idx, 1'b0};

  // b_sh is arithmetically shifted, so "remaining bits all equal" is all-0/all-1
`ifdef BOOTH_MUL_EARLY_TERM_EN
  assign skip = (b_sh == '0) || (b_sh == '1);
`else
  assign skip = 1'b0;
`endif

  assign a_top     = is_signed ? {2{a[WIDTH-1]}} : 2'b00;
  assign b_top     = is_signed ? {2{b[WIDTH-1]}} : 2'b00;
  assign in_ready  = rst_n && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign product   = acc[2*WIDTH-1:0];

  // FSM, operand capture and digit-serial accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_ext    <= '0;
      b_sh     <= '0;
      acc      <= '0;
      idx      <= '0;
      last_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_ext    <= {a_top, a};
            b_sh     <= {b_top, b, 1'b0};
            acc      <= '0;
            idx      <= '0;
            last_idx <= is_signed ? IW'(WIDTH/2 - 1) : IW'(WIDTH/2);
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (skip) begin
            state <= ST_DONE;
          end else begin
            acc  <= acc + addend;
            b_sh <= BW'($signed(b_sh) >>> 2);
            idx  <= idx + 1'b1;
            if (idx == last_idx) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed + random checks for booth_mul_seq (WIDTH=16).
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int checks = 0;
  int fails  = 0;

  booth_mul_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint px;
    longint py;
    longint r;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    r  = px * py;
    return r[31:0];
  endfunction

  // Issue one op, wait for out_valid, check product/latency; leaves DONE unacked
  task automatic issue(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                       input logic s, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = xa; b = xb; is_signed = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_product"}, 64'(product), 64'(exp));
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_ack_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ack_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int ls;
    int lu;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
`ifdef BOOTH_MUL_EARLY_TERM_EN
    ls = -1; lu = -1;
`else
    ls = 8; lu = 9;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    issue("neg3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, ls);
    ack("neg3x7");
    issue("min_sq", 16'h8000, 16'h8000, 1'b1, 32'h40000000, ls);
    ack("min_sq");
    issue("min_max", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, ls);
    ack("min_max");
    issue("u_max_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, lu);
    ack("u_max_sq");
    issue("s_m1_sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, ls);
    ack("s_m1_sq");

    // Back-pressure: hold DONE for 5 cycles, then back-to-back op
    issue("bp", 16'h8000, 16'h0002, 1'b0, 32'h00010000, lu);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_product", 64'(product), 64'h00010000);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    ack("bp");
    issue("b2b", 16'd300, 16'd200, 1'b0, 32'h0000EA60, lu);
    ack("b2b");

    // Reset in the middle of CALC
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; is_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_product", 64'(product), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    issue("post_rst", 16'd123, 16'hFFD3, 1'b1, 32'hFFFFEA61, ls);
    ack("post_rst");

`ifdef BOOTH_MUL_EARLY_TERM_EN
    issue("et_b0", 16'h1234, 16'h0000, 1'b1, 32'h00000000, 1);
    ack("et_b0");
    issue("et_b1", 16'h1234, 16'h0001, 1'b1, 32'h00001234, 2);
    ack("et_b1");
`endif

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      issue("rand", ra, rb, rs, ref_mul(ra, rb, rs), -1);
      ack("rand");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
